// File: rtl/axis_pkg.sv
// Shared constants and helpers for the AXI-Stream sink/source family.
package axis_pkg;

    localparam int AXIS_WIDTH_DEF = 32;
    localparam int CNT_WIDTH_DEF  = 16;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_sink_if.sv
// AXI-Stream handshake bundle between an upstream source and axis_sink.
interface axis_sink_if
    import axis_pkg::*;
#(
    parameter int AXIS_WIDTH = AXIS_WIDTH_DEF
) ();

    logic                  s_axis_tvalid;
    logic [AXIS_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tready;

    modport master (
        output s_axis_tvalid,
        output s_axis_tdata,
        input  s_axis_tready
    );

    modport slave (
        input  s_axis_tvalid,
        input  s_axis_tdata,
        output s_axis_tready
    );

endinterface

// File: rtl/axis_fifo_fwft.sv
// First-word-fall-through FIFO with wrap-bit pointers and a registered level.
module axis_fifo_fwft
    import axis_pkg::*;
#(
    parameter int WIDTH = AXIS_WIDTH_DEF,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push_i,
    input  logic [WIDTH-1:0]              push_data_i,
    input  logic                          pop_i,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [WIDTH-1:0]              head_o,
    output logic [level_width(DEPTH)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full_s, empty_s, push_s, pop_s;

    assign full_s  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_s = (wptr_q == rptr_q);
    assign push_s  = push_i && !full_s;
    assign pop_s   = pop_i && !empty_s;

    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign level_o = level_q;
    // Stale storage is hidden while empty so the head reads zero.
    assign head_o  = empty_s ? {WIDTH{1'b0}} : mem_q[rptr_q[AW-1:0]];

    // Next-state for pointers and occupancy.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1'b1);
            2'b01:   level_d = level_q - LW'(1'b1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= {(AW+1){1'b0}};
            rptr_q  <= {(AW+1){1'b0}};
            level_q <= {LW{1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/axis_sink.sv
// AXI-Stream sink: FWFT buffering, local read port, beat counter and
// incrementing-sequence checker.
module axis_sink
    import axis_pkg::*;
#(
    parameter int AXIS_WIDTH = AXIS_WIDTH_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int CHK_INC    = 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               en,
    input  logic                               clr,
    axis_sink_if.slave                         s_axis,
    input  logic                               rd_en,
    output logic                               rd_valid,
    output logic [AXIS_WIDTH-1:0]              rd_data,
    output logic [level_width(FIFO_DEPTH)-1:0] level,
    output logic [CNT_WIDTH-1:0]               beat_count,
    output logic [CNT_WIDTH-1:0]               err_count,
    output logic                               seq_err
);

    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [AXIS_WIDTH-1:0] INC     = AXIS_WIDTH'(CHK_INC);

    logic                  run_q;
    logic                  full_s, empty_s, tready_s, push_s;
    logic [CNT_WIDTH-1:0]  beat_q, beat_d, err_q, err_d;
    logic                  seq_err_q, seq_err_d, first_q, first_d;
    logic [AXIS_WIDTH-1:0] expect_q, expect_d;

    // run_q keeps tready low while reset is held and for the release cycle.
    assign tready_s             = en && run_q && !full_s;
    assign s_axis.s_axis_tready = tready_s;
    assign push_s               = s_axis.s_axis_tvalid && tready_s;
    assign rd_valid             = !empty_s;
    assign beat_count           = beat_q;
    assign err_count            = err_q;
    assign seq_err              = seq_err_q;

    axis_fifo_fwft #(
        .WIDTH (AXIS_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push_s),
        .push_data_i (s_axis.s_axis_tdata),
        .pop_i       (rd_en),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .head_o      (rd_data),
        .level_o     (level)
    );

    // Counter and checker next-state; clr wins over a same-cycle accept.
    always_comb begin
        beat_d    = beat_q;
        err_d     = err_q;
        seq_err_d = seq_err_q;
        first_d   = first_q;
        expect_d  = expect_q;
        if (clr) begin
            beat_d    = {CNT_WIDTH{1'b0}};
            err_d     = {CNT_WIDTH{1'b0}};
            seq_err_d = 1'b0;
            first_d   = 1'b1;
        end else if (push_s) begin
            if (beat_q != CNT_MAX) begin
                beat_d = beat_q + CNT_ONE;
            end else begin
                beat_d = beat_q;
            end
            if (first_q) begin
                first_d = 1'b0;
            end else if (s_axis.s_axis_tdata != expect_q) begin
                seq_err_d = 1'b1;
                if (err_q != CNT_MAX) begin
                    err_d = err_q + CNT_ONE;
                end else begin
                    err_d = err_q;
                end
            end else begin
                first_d = 1'b0;
            end
            expect_d = s_axis.s_axis_tdata + INC;
        end else begin
            beat_d = beat_q;
        end
    end

    // Counter, checker and run-enable registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q     <= 1'b0;
            beat_q    <= {CNT_WIDTH{1'b0}};
            err_q     <= {CNT_WIDTH{1'b0}};
            seq_err_q <= 1'b0;
            first_q   <= 1'b1;
            expect_q  <= {AXIS_WIDTH{1'b0}};
        end else begin
            run_q     <= 1'b1;
            beat_q    <= beat_d;
            err_q     <= err_d;
            seq_err_q <= seq_err_d;
            first_q   <= first_d;
            expect_q  <= expect_d;
        end
    end

endmodule

// File: tb/tb_axis_sink.sv
// Randomised and directed bench for axis_sink against a queue-based model.
module tb_axis_sink;
    import axis_pkg::*;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int LW = level_width(D);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, en, clr, rd_en, tvalid;
    logic [W-1:0]  tdata;
    logic          rd_valid, seq_err, s_rd_valid, s_seq_err;
    logic [W-1:0]  rd_data, s_rd_data;
    logic [LW-1:0] level, s_level;
    logic [15:0]   beat_count, err_count;
    logic [3:0]    s_beat_count, s_err_count;

    axis_sink_if #(.AXIS_WIDTH(W)) if_m ();
    axis_sink_if #(.AXIS_WIDTH(W)) if_s ();
    assign if_m.s_axis_tvalid = tvalid;
    assign if_m.s_axis_tdata  = tdata;
    assign if_s.s_axis_tvalid = tvalid;
    assign if_s.s_axis_tdata  = tdata;

    axis_sink #(.AXIS_WIDTH(W), .FIFO_DEPTH(D), .CNT_WIDTH(16), .CHK_INC(1)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .s_axis(if_m),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
        .beat_count(beat_count), .err_count(err_count), .seq_err(seq_err));

    axis_sink #(.AXIS_WIDTH(W), .FIFO_DEPTH(D), .CNT_WIDTH(4), .CHK_INC(1)) dut_sat (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .s_axis(if_s),
        .rd_en(rd_en), .rd_valid(s_rd_valid), .rd_data(s_rd_data), .level(s_level),
        .beat_count(s_beat_count), .err_count(s_err_count), .seq_err(s_seq_err));

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] q_m[$];
    int           beat_m, err_m, sat_m;
    bit           seq_m, first_m, run_m, acc_last;
    logic [W-1:0] exp_m;

    task automatic model_reset();
        q_m.delete();
        beat_m = 0; err_m = 0; sat_m = 0;
        seq_m = 1'b0; first_m = 1'b1; run_m = 1'b0; exp_m = '0;
    endtask

    function automatic bit model_ready();
        return en && run_m && (q_m.size() < D);
    endfunction

    // One clock: decide accept/pop from pre-edge inputs, then update the model.
    task automatic clk_step();
        bit acc, pop, c;
        logic [W-1:0] d;
        acc = tvalid && model_ready();
        pop = rd_en && (q_m.size() > 0);
        d = tdata;
        c = clr;
        @(posedge clk);
        if (pop) q_m.delete(0);
        if (acc) q_m.push_back(d);
        run_m = 1'b1;
        if (c) begin
            beat_m = 0; err_m = 0; sat_m = 0; seq_m = 1'b0; first_m = 1'b1;
        end else if (acc) begin
            if (beat_m < 65535) beat_m++;
            if (sat_m < 15) sat_m++;
            if (first_m) first_m = 1'b0;
            else if (d !== exp_m) begin
                if (err_m < 65535) err_m++;
                seq_m = 1'b1;
            end
            exp_m = d + 32'd1;
        end
        acc_last = acc;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b1; clr = 1'b0; rd_en = 1'b0; tvalid = 1'b0; tdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (if_m.s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b expected 0", if_m.s_axis_tready); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid: got %b expected 0", rd_valid); end
        n_checks++; if (level !== LW'(0)) begin n_fail++; $display("FAIL rst_level: got %0d expected 0", level); end
        n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL rst_rd_data: got %h expected 0", rd_data); end
        n_checks++; if (beat_count !== 16'd0 || err_count !== 16'd0 || seq_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_counters: got beat=%0d err=%0d seq=%b expected 0/0/0", beat_count, err_count, seq_err); end
        reset_n = 1'b1;
        clk_step();
        n_checks++; if (if_m.s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL rst_release_tready: got %b expected 1", if_m.s_axis_tready); end
    endtask

    task automatic test_stream();
        en = 1'b1; rd_en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tvalid = 1'b1; tdata = W'(i);
            clk_step();
            n_checks++; if (rd_valid !== 1'b1 || rd_data !== W'(i)) begin
                n_fail++; $display("FAIL stream_data: got valid=%b data=%0d expected 1/%0d", rd_valid, rd_data, i); end
            n_checks++; if (level > LW'(1)) begin n_fail++; $display("FAIL stream_level: got %0d expected <=1", level); end
        end
        tvalid = 1'b0;
        clk_step();
        n_checks++; if (beat_count !== 16'd10) begin n_fail++; $display("FAIL stream_beats: got %0d expected 10", beat_count); end
        n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL stream_errs: got %0d expected 0", err_count); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got %b expected 0", rd_valid); end
    endtask

    task automatic test_backpressure();
        int k;
        k = 0; rd_en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tvalid = 1'b1; tdata = W'(11 + k);
            clk_step();
            if (acc_last) k++;
        end
        n_checks++; if (level !== LW'(4)) begin n_fail++; $display("FAIL bp_level_full: got %0d expected 4", level); end
        n_checks++; if (if_m.s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL bp_tready_full: got %b expected 0", if_m.s_axis_tready); end
        rd_en = 1'b1;
        clk_step();
        n_checks++; if (level !== LW'(3) || if_m.s_axis_tready !== 1'b1) begin
            n_fail++; $display("FAIL bp_after_pop: got level=%0d tready=%b expected 3/1", level, if_m.s_axis_tready); end
        rd_en = 1'b0;
        clk_step();
        tvalid = 1'b0;
        n_checks++; if (level !== LW'(4) || beat_count !== 16'd15) begin
            n_fail++; $display("FAIL bp_fifth_accept: got level=%0d beats=%0d expected 4/15", level, beat_count); end
        rd_en = 1'b1;
        for (int j = 0; j < 4; j++) begin
            n_checks++; if (rd_data !== W'(12 + j)) begin n_fail++; $display("FAIL bp_drain_data: got %0d expected %0d", rd_data, 12 + j); end
            clk_step();
        end
        n_checks++; if (rd_valid !== 1'b0 || err_count !== 16'd0) begin
            n_fail++; $display("FAIL bp_end: got valid=%b err=%0d expected 0/0", rd_valid, err_count); end
        rd_en = 1'b0;
    endtask

    task automatic test_seq_err();
        logic [W-1:0] vals [4];
        int           errs [4];
        vals = '{32'd7, 32'd8, 32'd20, 32'd21};
        errs = '{0, 0, 1, 1};
        clr = 1'b1; clk_step(); clr = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tvalid = 1'b1; tdata = vals[i];
            clk_step();
            n_checks++; if (err_count !== 16'(errs[i]) || seq_err !== (errs[i] != 0)) begin
                n_fail++; $display("FAIL seq_err_%0d: got err=%0d seq=%b expected %0d/%b", i, err_count, seq_err, errs[i], errs[i] != 0); end
        end
        tvalid = 1'b0;
        clk_step();
    endtask

    task automatic test_wrap_clr();
        clr = 1'b1; clk_step(); clr = 1'b0;
        rd_en = 1'b1;
        tvalid = 1'b1; tdata = 32'hFFFF_FFFF; clk_step();
        tdata = 32'h0000_0000; clk_step();
        tvalid = 1'b0; clk_step();
        n_checks++; if (err_count !== 16'd0 || seq_err !== 1'b0) begin
            n_fail++; $display("FAIL wrap_no_err: got err=%0d seq=%b expected 0/0", err_count, seq_err); end
        rd_en = 1'b0; clr = 1'b1; tvalid = 1'b1; tdata = 32'h55;
        clk_step();
        clr = 1'b0; tvalid = 1'b0;
        n_checks++; if (beat_count !== 16'd0 || level !== LW'(1) || rd_data !== 32'h55) begin
            n_fail++; $display("FAIL clr_with_beat: got beats=%0d level=%0d data=%h expected 0/1/55", beat_count, level, rd_data); end
        tvalid = 1'b1; tdata = 32'h99; clk_step();
        n_checks++; if (err_count !== 16'd0 || beat_count !== 16'd1) begin
            n_fail++; $display("FAIL clr_first: got err=%0d beats=%0d expected 0/1", err_count, beat_count); end
        tdata = 32'h10; clk_step();
        tvalid = 1'b0;
        n_checks++; if (err_count !== 16'd1 || seq_err !== 1'b1) begin
            n_fail++; $display("FAIL clr_checker_live: got err=%0d seq=%b expected 1/1", err_count, seq_err); end
        rd_en = 1'b1;
        repeat (3) clk_step();
        rd_en = 1'b0;
    endtask

    task automatic test_reset_midop_sat();
        int sent;
        rd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tvalid = 1'b1; tdata = W'(100 + i); clk_step();
        end
        tvalid = 1'b0;
        n_checks++; if (level !== LW'(3)) begin n_fail++; $display("FAIL midop_level3: got %0d expected 3", level); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (level !== LW'(0) || rd_valid !== 1'b0 || if_m.s_axis_tready !== 1'b0 || beat_count !== 16'd0) begin
            n_fail++; $display("FAIL midop_async_reset: got level=%0d valid=%b tready=%b beats=%0d expected 0/0/0/0",
                               level, rd_valid, if_m.s_axis_tready, beat_count); end
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        sent = 0; rd_en = 1'b1;
        for (int c = 0; c < 40 && sent < 20; c++) begin
            tvalid = 1'b1; tdata = W'(sent);
            clk_step();
            if (acc_last) sent++;
        end
        tvalid = 1'b0;
        n_checks++; if (sent != 20) begin n_fail++; $display("FAIL sat_budget: got %0d beats sent expected 20", sent); end
        n_checks++; if (s_beat_count !== 4'd15) begin n_fail++; $display("FAIL sat_beat_count: got %0d expected 15", s_beat_count); end
        n_checks++; if (beat_count !== 16'd20 || err_count !== 16'd0) begin
            n_fail++; $display("FAIL sat_wide_count: got beats=%0d err=%0d expected 20/0", beat_count, err_count); end
        clk_step();
    endtask

    task automatic test_random();
        logic [W-1:0] last;
        bit           pend;
        last = 32'd500; pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            en    = ($urandom_range(7, 0) != 0);
            rd_en = $urandom_range(1, 0);
            clr   = ($urandom_range(63, 0) == 0);
            if (!pend) begin
                tvalid = ($urandom_range(3, 0) != 0);
                if (tvalid) begin
                    last  = ($urandom_range(7, 0) == 0) ? $urandom() : last + 32'd1;
                    tdata = last;
                end
            end
            clk_step();
            pend = tvalid && !acc_last;
            n_checks++; if (rd_valid !== (q_m.size() > 0) || level !== LW'(q_m.size())) begin
                n_fail++; $display("FAIL rnd_occupancy: got valid=%b level=%0d expected %b/%0d", rd_valid, level, q_m.size() > 0, q_m.size()); end
            if (q_m.size() > 0) begin
                n_checks++; if (rd_data !== q_m[0]) begin n_fail++; $display("FAIL rnd_head: got %h expected %h", rd_data, q_m[0]); end
            end
            n_checks++; if (if_m.s_axis_tready !== model_ready()) begin
                n_fail++; $display("FAIL rnd_tready: got %b expected %b", if_m.s_axis_tready, model_ready()); end
            n_checks++; if (beat_count !== 16'(beat_m) || err_count !== 16'(err_m) || seq_err !== seq_m || s_beat_count !== 4'(sat_m)) begin
                n_fail++; $display("FAIL rnd_counters: got beat=%0d err=%0d seq=%b sat=%0d expected %0d/%0d/%b/%0d",
                                   beat_count, err_count, seq_err, s_beat_count, beat_m, err_m, seq_m, sat_m); end
        end
        tvalid = 1'b0; clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_seq_err();
        test_wrap_clr();
        test_reset_midop_sat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_sink.md
Name: axis_sink

Overview:
AXI-Stream slave stage that sits directly downstream of axis_source and consumes its m_axis_* output. It buffers accepted beats in a small first-word-fall-through FIFO, drains them to a local read port, and counts accepted beats. It also checks each beat against an expected sequence (previous + CHK_INC) and flags mismatches. It is used as the standard sink in stream benches and as a buffering consumer in RTL.

Parameters:
AXIS_WIDTH, 32, tdata width in bits
FIFO_DEPTH, 4, FIFO entries; power of 2, minimum 2
CNT_WIDTH, 16, width of beat_count and err_count
CHK_INC, 1, expected increment between consecutive beats (0 = constant stream)

Ports:
clk  input  1  clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
en  input  1  sink enable; gates s_axis_tready
clr  input  1  synchronous clear of counters, error flag and checker state; FIFO contents kept
s_axis_tvalid  input  1  upstream beat valid
s_axis_tdata  input  AXIS_WIDTH  upstream beat data
s_axis_tready  output  1  sink ready
rd_en  input  1  pop request on the local read port
rd_valid  output  1  FIFO non-empty
rd_data  output  AXIS_WIDTH  FIFO head, valid when rd_valid=1
level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
beat_count  output  CNT_WIDTH  accepted beats, saturating
err_count  output  CNT_WIDTH  sequence mismatches, saturating
seq_err  output  1  sticky mismatch flag

Behaviour:
- Reset (reset_n=0, asynchronous): FIFO empty, level=0, rd_valid=0, rd_data=0, s_axis_tready=0, beat_count=0, err_count=0, seq_err=0, checker "first" flag set. Release is synchronous to clk.
- s_axis_tready = en && !full. It is combinational from registered state only and never depends on s_axis_tvalid.
- Accept (push) happens on a rising edge when s_axis_tvalid && s_axis_tready. tdata is written at the write pointer. level updates on the same edge.
- Pop happens when rd_en && rd_valid. rd_en while empty is ignored.
- FWFT read port: rd_data presents the head combinationally from storage, with no read latency. A pushed beat is visible on rd_data the cycle after the accepting edge.
- Latency: an accepted beat reaches rd_valid in 1 cycle.
- Push and pop in the same cycle (not full, not empty): level is unchanged and both pointers advance.
- Full: tready=0 even if rd_en is asserted in the same cycle, so there is no pass-through on full. A beat is accepted the cycle after the pop.
- Empty with push: level goes 0->1 and there is no bypass.
- Pointers have log2(FIFO_DEPTH)+1 bits with a wrap bit. Full = MSBs differ and LSBs equal. Empty = pointers equal.
- en deasserted mid-stream: tready falls in the same cycle. The upstream beat stays pending per AXIS rules. FIFO draining continues.
- Checker (runs only on accepted beats):
  - First flag set: load expected = tdata + CHK_INC, clear the first flag, no error.
  - Otherwise, on tdata != expected: err_count +1 (saturating) and seq_err=1.
  - In all cases after the first beat, expected = tdata + CHK_INC. The checker resyncs to the received value.
  - Addition is modulo 2^AXIS_WIDTH; all-ones followed by 0 is legal for CHK_INC=1.
- beat_count increments on every accepted beat and saturates at all-ones.
- clr=1: beat_count=0, err_count=0, seq_err=0, first flag set. FIFO and pointers are untouched.
  - clr has priority over an accept in the same cycle. That beat still enters the FIFO but is not counted or checked.
- Reset mid-operation: everything returns to reset values immediately and any buffered data is discarded.

Decomposition:
- Shared package axis_pkg:
  - AXIS_WIDTH default constant
  - a function computing level width: clog2(depth)+1
  - CNT_WIDTH default
- One sub-module, axis_fifo_fwft (storage, pointers, full/empty, level). It is reusable by axis_source-side buffering.
- The checker and counters stay in axis_sink.

Test Plan:
- Reset values: hold reset_n=0 for 3 cycles -> s_axis_tready=0, rd_valid=0, level=0, beat_count=0, err_count=0, seq_err=0; after release with en=1 -> tready=1.
- Streaming with drain: en=1, rd_en=1, upstream sends 1,2,3..10 back-to-back -> rd_data delivers 1..10 in order, each one cycle after acceptance; beat_count=10; err_count=0; level never exceeds 1.
- Back-pressure: rd_en=0, send 5 beats -> first 4 accepted, level=4, tready=0, beat 5 held; pulse rd_en for 1 cycle -> beat 5 accepted on the following edge, level=4.
- Sequence error: send 7,8,20,21 -> err_count=1, seq_err=1 after the beat 20; the beat 21 produces no further error.
- Wrap and clr: send 0xFFFFFFFF,0x00000000 -> no error; assert clr with a simultaneous beat -> counters 0 and FIFO keeps the beat; the next beat is treated as first (no error).
- Reset mid-op and saturation: with FIFO at level 3, drop reset_n asynchronously between edges -> level=0 and rd_valid=0 immediately; with CNT_WIDTH=4, send 20 beats -> beat_count holds at 15.
